// File: rtl/secant_solver.sv
// secant_solver: secant-method bias-current controller with handshake, sequential divider and clamping.
// Optional SECANT_BISECT_FALLBACK_EN: a zero divisor bisects the bracket instead of failing.
module secant_solver #(
  parameter int BUS_WIDTH = 10,
  parameter int TOL       = 30,
  parameter int MAX_ITER  = 16,
  parameter int A_INIT    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [BUS_WIDTH-1:0]            q_desired,
  input  logic [BUS_WIDTH-1:0]            i_ref_setup,
  input  logic [BUS_WIDTH-1:0]            q_measured,
  input  logic                            meas_valid,
  output logic [BUS_WIDTH-1:0]            i_ref,
  output logic                            i_ref_valid,
  output logic                            busy,
  output logic                            converged,
  output logic                            went_unstable,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);
  localparam int W  = BUS_WIDTH;
  localparam int NW = 2*W+2;
  localparam int DW = W+2;
  localparam int IW = $clog2(MAX_ITER+1);
  localparam int CW = $clog2(NW+1);
  localparam logic signed [W:0] TOL_V = (W+1)'(TOL);
  localparam logic signed [W:0] A_V = (W+1)'(A_INIT);
  localparam logic [IW-1:0] LAST_IT = IW'(MAX_ITER-1);

  typedef enum logic [3:0] {IDLE, DRV_A, WAIT_A, DRV_B, WAIT_B, CALC, DRV_C, WAIT_C, DONE, FAIL} state_t;
  state_t state;

  logic [W-1:0] q_des;
  logic signed [W:0] a, b, c, f_a, f_b, f_m, f_abs;
  logic signed [DW-1:0] d_ba, den;
  logic signed [NW-1:0] num;
  logic [NW-1:0] num_mag, quo;
  logic [DW-1:0] den_mag, dvs, rem, rem_sub;
  logic [DW:0] rem_sh;
  logic signed [NW:0] q_s, c_w;
  logic [W-1:0] c_cl;
  logic [CW-1:0] div_cnt;
  logic neg, div_go, conv, ge;

  assign f_m     = $signed({1'b0, q_measured}) - $signed({1'b0, q_des});
  assign f_abs   = f_m[W] ? -f_m : f_m;
  assign conv    = f_abs <= TOL_V;
  assign d_ba    = DW'(b) - DW'(a);
  assign num     = NW'(f_b) * NW'(d_ba);
  assign den     = DW'(f_b) - DW'(f_a);
  assign num_mag = num[NW-1] ? -num : num;
  assign den_mag = den[DW-1] ? -den : den;
  // restoring divider: one quotient bit per cycle, dividend shifts out of quo
  assign rem_sh  = {rem, quo[NW-1]};
  assign ge      = rem_sh >= {1'b0, dvs};
  assign rem_sub = rem_sh[DW-1:0] - dvs;
  assign q_s     = neg ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
  assign c_w     = (NW+1)'(b) - q_s;
  assign c_cl    = c_w[NW] ? '0 : (|c_w[NW-1:W]) ? '1 : c_w[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      i_ref         <= '0;
      i_ref_valid   <= 1'b0;
      busy          <= 1'b0;
      converged     <= 1'b0;
      went_unstable <= 1'b0;
      iter_count    <= '0;
      div_go        <= 1'b0;
    end else begin
      i_ref_valid <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: if (start) begin
          state         <= DRV_A;
          busy          <= 1'b1;
          converged     <= 1'b0;
          went_unstable <= 1'b0;
          iter_count    <= '0;
          q_des         <= q_desired;
          a             <= A_V;
          b             <= {1'b0, i_ref_setup};
        end
        DRV_A: begin
          i_ref       <= a[W-1:0];
          i_ref_valid <= 1'b1;
          state       <= WAIT_A;
        end
        WAIT_A: if (meas_valid) begin
          f_a <= f_m;
          if (conv) begin
            state     <= DONE;
            busy      <= 1'b0;
            converged <= 1'b1;
          end else state <= DRV_B;
        end
        DRV_B: begin
          i_ref       <= b[W-1:0];
          i_ref_valid <= 1'b1;
          state       <= WAIT_B;
        end
        WAIT_B: if (meas_valid) begin
          f_b <= f_m;
          if (conv) begin
            state     <= DONE;
            busy      <= 1'b0;
            converged <= 1'b1;
          end else state <= CALC;
        end
        CALC: if (!div_go) begin
          if (den == '0) begin
`ifdef SECANT_BISECT_FALLBACK_EN
            c     <= (W+1)'(($signed({a[W], a}) + $signed({b[W], b})) >>> 1);
            state <= DRV_C;
`else
            state         <= FAIL;
            busy          <= 1'b0;
            went_unstable <= 1'b1;
`endif
          end else begin
            quo     <= num_mag;
            rem     <= '0;
            dvs     <= den_mag;
            neg     <= num[NW-1] ^ den[DW-1];
            div_cnt <= CW'(NW);
            div_go  <= 1'b1;
          end
        end else if (div_cnt != '0) begin
          quo     <= {quo[NW-2:0], ge};
          rem     <= ge ? rem_sub : rem_sh[DW-1:0];
          div_cnt <= div_cnt - 1'b1;
        end else begin
          c      <= {1'b0, c_cl};
          div_go <= 1'b0;
          state  <= DRV_C;
        end
        DRV_C: begin
          i_ref       <= c[W-1:0];
          i_ref_valid <= 1'b1;
          state       <= WAIT_C;
        end
        WAIT_C: if (meas_valid) begin
          iter_count <= iter_count + 1'b1;
          a          <= b;
          f_a        <= f_b;
          b          <= c;
          f_b        <= f_m;
          if (conv) begin
            state     <= DONE;
            busy      <= 1'b0;
            converged <= 1'b1;
          end else if (iter_count == LAST_IT) begin
            state         <= FAIL;
            busy          <= 1'b0;
            went_unstable <= 1'b1;
          end else state <= CALC;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_secant_solver.sv
// tb_secant_solver: table of solves against behavioural plants, scoreboarded i_ref sequence, plus reset/start corner cases.
module tb_secant_solver;
  localparam int W = 10;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, meas_valid = 1'b0;
  logic [W-1:0] q_desired = '0, i_ref_setup = '0, q_measured = '0;
  logic [W-1:0] i_ref;
  logic i_ref_valid, busy, converged, went_unstable;
  logic [4:0] iter_count;

  always #5 clk = ~clk;

  secant_solver #(.BUS_WIDTH(W), .TOL(30), .MAX_ITER(16), .A_INIT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .q_desired(q_desired), .i_ref_setup(i_ref_setup),
    .q_measured(q_measured), .meas_valid(meas_valid), .i_ref(i_ref), .i_ref_valid(i_ref_valid),
    .busy(busy), .converged(converged), .went_unstable(went_unstable), .iter_count(iter_count)
  );

  typedef struct {int mode; int qd; int setup; int conv; int fail; int iter;} vec_t;
  vec_t tv[7];
  int checks = 0, fails = 0, pulses = 0;
  int exp_q[$];
  int plant_en = 0, plant_mode = 0, plant_qd = 0, meas_k = 0, px;

  // 0: q=i/4+22  1: flat 100  2: q=300-i/4  3: target +/-60 alternating per measurement
  function automatic int plant(input int mode, input int i, input int qd, input int k);
    return mode == 0 ? i/4 + 22 : mode == 1 ? 100 : mode == 2 ? 300 - i/4 : (k % 2 == 0 ? qd + 60 : qd - 60);
  endfunction

  function automatic int iabs(input int x);
    return x < 0 ? -x : x;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // behavioural secant reference: pushes expected i_ref sequence
  task automatic predict(input int mode, input int qd, input int setup, output int last);
    int a, b, c, fa, fb, fc, it, k;
    k = 0; it = 0; a = 0;
    exp_q.push_back(a); last = a;
    fa = plant(mode, a, qd, k) - qd; k++;
    if (iabs(fa) <= 30) return;
    b = setup;
    exp_q.push_back(b); last = b;
    fb = plant(mode, b, qd, k) - qd; k++;
    if (iabs(fb) <= 30) return;
    while (1) begin
      if (fb == fa) begin
`ifdef SECANT_BISECT_FALLBACK_EN
        c = (a + b) / 2;
`else
        return;
`endif
      end else begin
        c = b - (fb * (b - a)) / (fb - fa);
        c = c < 0 ? 0 : c > 1023 ? 1023 : c;
      end
      exp_q.push_back(c); last = c;
      fc = plant(mode, c, qd, k) - qd; k++;
      it++;
      if (iabs(fc) <= 30 || it == 16) return;
      a = b; fa = fb; b = c; fb = fc;
    end
  endtask

  always @(negedge clk) if (i_ref_valid) begin
    pulses++;
    if (exp_q.size() == 0) begin
      checks++; fails++;
      $display("FAIL spurious_i_ref_valid: i_ref=%0d with no expected value", i_ref);
    end else check("i_ref_seq", int'(i_ref), exp_q.pop_front());
  end

  initial forever begin
    @(negedge clk);
    if (plant_en != 0 && i_ref_valid) begin
      px = int'(i_ref);
      repeat (2) @(negedge clk);
      q_measured = W'(plant(plant_mode, px, plant_qd, meas_k));
      meas_k++;
      meas_valid = 1'b1;
      @(negedge clk);
      meas_valid = 1'b0;
    end
  end

  task automatic settle(input int conv, input int fail, input int iter, input int last, input string nm);
    int n;
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; fails++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", nm, busy, n);
    end
    check({nm, "_converged"}, int'(converged), conv);
    check({nm, "_unstable"}, int'(went_unstable), fail);
    check({nm, "_iter"}, int'(iter_count), iter);
    check({nm, "_i_ref"}, int'(i_ref), last);
    check({nm, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic run(input vec_t v, input string nm);
    int last;
    predict(v.mode, v.qd, v.setup, last);
    plant_mode = v.mode; plant_qd = v.qd; meas_k = 0; plant_en = 1;
    q_desired = W'(v.qd); i_ref_setup = W'(v.setup); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({nm, "_busy"}, int'(busy), 1);
    settle(v.conv, v.fail, v.iter, last, nm);
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_i_ref"}, int'(i_ref), 0);
    check({nm, "_converged"}, int'(converged), 0);
    check({nm, "_unstable"}, int'(went_unstable), 0);
    check({nm, "_iter"}, int'(iter_count), 0);
  endtask

  initial begin
    int p0, last;
    tv[0] = '{0, 258, 600, 1, 0, 1};
    tv[1] = '{0, 258, 1000, 1, 0, 0};
    tv[2] = '{0, 52, 600, 1, 0, 0};
    tv[3] = '{0, 53, 600, 1, 0, 1};
`ifdef SECANT_BISECT_FALLBACK_EN
    tv[4] = '{1, 258, 1000, 0, 1, 16};
    tv[5] = '{2, 400, 1000, 0, 1, 16};
`else
    tv[4] = '{1, 258, 1000, 0, 1, 0};
    tv[5] = '{2, 400, 1000, 0, 1, 2};
`endif
    tv[6] = '{3, 500, 1000, 0, 1, 16};
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      run(tv[i], $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end
    // reset while waiting for the second measurement
    plant_en = 0;
    exp_q.push_back(0); exp_q.push_back(1000);
    q_desired = 10'd258; i_ref_setup = 10'd1000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    q_measured = 10'd100; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("wait_b_busy", int'(busy), 1);
    check("wait_b_pending", exp_q.size(), 0);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_idle("rst_wait_b");
    p0 = pulses;
    repeat (3) begin meas_valid = 1'b1; @(negedge clk); meas_valid = 1'b0; @(negedge clk); end
    repeat (5) @(negedge clk);
    check("rst_wait_b_quiet", pulses, p0);
    // reset in the middle of the divide
    exp_q.push_back(0); exp_q.push_back(600);
    i_ref_setup = 10'd600; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    q_measured = 10'd22; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    repeat (3) @(negedge clk);
    q_measured = 10'd172; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("calc_busy", int'(busy), 1);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_idle("rst_calc");
    p0 = pulses;
    repeat (40) @(negedge clk);
    check("rst_calc_quiet", pulses, p0);
    check("rst_calc_pending", exp_q.size(), 0);
    // meas_valid held in IDLE, then start re-pulsed mid-solve
    q_measured = 10'd258; meas_valid = 1'b1;
    repeat (6) @(negedge clk);
    meas_valid = 1'b0;
    check("idle_meas_quiet", pulses, p0);
    check("idle_meas_busy", int'(busy), 0);
    predict(0, 258, 600, last);
    plant_mode = 0; plant_qd = 258; meas_k = 0; plant_en = 1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    settle(1, 0, 1, last, "restart_busy");
    check("restart_pulses", pulses - p0, 3);
    // start and meas_valid together in DONE
    plant_en = 0;
    repeat (2) @(negedge clk);
    predict(0, 258, 1000, last);
    meas_k = 0; i_ref_setup = 10'd1000;
    start = 1'b1; meas_valid = 1'b1; q_measured = 10'd258;
    @(negedge clk); start = 1'b0; meas_valid = 1'b0; plant_en = 1;
    check("start_wins_busy", int'(busy), 1);
    settle(1, 0, 0, last, "start_wins");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
